// File: rtl/sram_bridge.sv
// Bridges the core's fetch and data ports onto one async 32-bit SRAM.
// Reads are combinational; writes run a strobe FSM that stalls the core.
module sram_bridge #(
  parameter int ADDR_W    = 20,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [31:0]       ram_data_i,
  output logic [31:0]       ram_data_o,
  output logic              busy_o,
  output logic              wr_ack_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    WSETUP,
    WPULSE,
    WHOLD,
    WDONE
  } state_t;

  state_t              state_q;
  logic [3:0]          wcnt_q;
  logic                armed_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic                wok_q;

  logic                wr_req;
  logic                rd_ram;
  logic                accept;
  logic                ram_ok;
  logic                rom_ok;
  logic [ADDR_W-1:0]   ram_wa;
  logic [ADDR_W-1:0]   rom_wa;
  logic                unused_lsb;

  assign ram_wa     = ram_addr_i[ADDR_W+1:2];
  assign rom_wa     = rom_addr_i[ADDR_W+1:2];
  assign ram_ok     = ~|ram_addr_i[31:ADDR_W+2];
  assign rom_ok     = ~|rom_addr_i[31:ADDR_W+2];
  assign unused_lsb = ^{ram_addr_i[1:0], rom_addr_i[1:0]};

  assign wr_req = ram_ce_i & ram_we_i;
  assign rd_ram = ram_ce_i & ~ram_we_i;
  assign accept = (state_q == IDLE) & wr_req & armed_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      armed_q <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      wok_q   <= 1'b0;
    end else begin
      // A store still held at ack time must not be written again
      if (state_q == WDONE)
        armed_q <= ~wr_req;
      else if (!wr_req)
        armed_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            waddr_q <= ram_wa;
            wdata_q <= ram_data_i;
            wok_q   <= ram_ok;
            state_q <= WSETUP;
          end
        end
        WSETUP: begin
          wcnt_q  <= 4'(WE_CYCLES - 1);
          state_q <= WPULSE;
        end
        WPULSE: begin
          if (wcnt_q == 4'd0)
            state_q <= WHOLD;
          else
            wcnt_q <= wcnt_q - 4'd1;
        end
        WHOLD:   state_q <= WDONE;
        WDONE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o      = 1'b0;
    wr_ack_o    = 1'b0;
    rom_data_o  = '0;
    ram_data_o  = '0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr_o = '0;
    sram_dq_o   = '0;

    unique case (state_q)
      IDLE: begin
        busy_o = accept;
        if (rd_ram) begin
          sram_addr_o = ram_wa;
          if (ram_ok) begin
            sram_ce_n  = 1'b0;
            sram_oe_n  = 1'b0;
            ram_data_o = sram_dq_i;
          end
        end else if (rom_ce_i) begin
          sram_addr_o = rom_wa;
          if (rom_ok) begin
            sram_ce_n  = 1'b0;
            sram_oe_n  = 1'b0;
            rom_data_o = sram_dq_i;
          end
        end
      end
      WSETUP, WPULSE, WHOLD: begin
        busy_o      = 1'b1;
        sram_ce_n   = ~wok_q;
        sram_we_n   = (state_q == WPULSE) ? ~wok_q : 1'b1;
        sram_dq_oe  = 1'b1;
        sram_addr_o = waddr_q;
        sram_dq_o   = wdata_q;
      end
      WDONE:   wr_ack_o = 1'b1;
      default: ;
    endcase

    // Gate combinationally so a reset aborts a write in the same cycle
    if (!rst) begin
      busy_o      = 1'b0;
      wr_ack_o    = 1'b0;
      rom_data_o  = '0;
      ram_data_o  = '0;
      sram_ce_n   = 1'b1;
      sram_oe_n   = 1'b1;
      sram_we_n   = 1'b1;
      sram_dq_oe  = 1'b0;
      sram_addr_o = '0;
      sram_dq_o   = '0;
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with a small behavioural SRAM.
// Each task drives one scenario and checks its own results.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        busy_o;
  logic        wr_ack_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_dq_i;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  sram_bridge #(.ADDR_W(20), .WE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ram_ce_i   (ram_ce_i),
    .ram_we_i   (ram_we_i),
    .ram_addr_i (ram_addr_i),
    .ram_data_i (ram_data_i),
    .ram_data_o (ram_data_o),
    .busy_o     (busy_o),
    .wr_ack_o   (wr_ack_o),
    .sram_addr_o(sram_addr_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  int          nwrites = 0;
  logic        prev_we = 1'b1;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (prev_we) nwrites++;
      mem[sram_addr_o[7:0]] = sram_dq_o;
    end
    prev_we = sram_we_n;
  end

  int n_pass = 0;
  int n_tot  = 0;

  int   ack_at, ack_cnt, busy_cnt, we_lo, we_bad, ce_lo, rom_nz;
  logic busy0;
  int   w0;

  task automatic idle_inputs();
    rom_ce_i   = 1'b0;
    rom_addr_i = 32'h0;
    ram_ce_i   = 1'b0;
    ram_we_i   = 1'b0;
    ram_addr_i = 32'h0;
    ram_data_i = 32'h0;
  endtask

  task automatic observe(input int n, input logic [19:0] wa);
    ack_at = -1; ack_cnt = 0; busy_cnt = 0; busy0 = 1'b0;
    we_lo = 0; we_bad = 0; ce_lo = 0; rom_nz = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) busy0 = busy_o;
      else if (busy_o) busy_cnt++;
      if (wr_ack_o) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = i;
      end
      if (!sram_we_n) begin
        we_lo++;
        if (sram_addr_o != wa) we_bad++;
      end
      if (i > 0 && !sram_ce_n) ce_lo++;
      if (i >= 1 && i <= 5 && rom_data_o != 32'h0) rom_nz++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [121:0] obs;
    logic [121:0] exp_v;
    exp_v = {2'b00, 64'h0, 4'b1110, 20'h0, 32'h0};
    rst = 1'b0;
    rom_ce_i = 1'b1; rom_addr_i = 32'h10;
    ram_ce_i = 1'b1; ram_we_i = 1'b1;
    ram_addr_i = 32'h40; ram_data_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {busy_o, wr_ack_o, rom_data_o, ram_data_o, sram_ce_n,
             sram_oe_n, sram_we_n, sram_dq_oe, sram_addr_o, sram_dq_o};
      n_tot++;
      if (obs !== exp_v)
        $display("FAIL reset_out[%0d]: got %h want %h", i, obs, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_tot++;
    if ({busy_o, wr_ack_o} !== 2'b00)
      $display("FAIL reset_release: got busy/ack %b want 00", {busy_o, wr_ack_o});
    else n_pass++;
    n_tot++;
    if (nwrites !== 0)
      $display("FAIL reset_nowrite: got %0d writes want 0", nwrites);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_0010;
    @(negedge clk);
    n_tot++;
    if (sram_addr_o !== 20'd4)
      $display("FAIL fetch_addr: got %h want %h", sram_addr_o, 20'd4);
    else n_pass++;
    n_tot++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, busy_o} !== 4'b0010)
      $display("FAIL fetch_strobes: got %b want 0010",
               {sram_ce_n, sram_oe_n, sram_we_n, busy_o});
    else n_pass++;
    n_tot++;
    if (rom_data_o !== 32'h2401_0005)
      $display("FAIL fetch_data: got %h want 24010005", rom_data_o);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_priority();
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_0010;
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h0000_0020;
    @(negedge clk);
    n_tot++;
    if (sram_addr_o !== 20'd8)
      $display("FAIL prio_addr: got %h want %h", sram_addr_o, 20'd8);
    else n_pass++;
    n_tot++;
    if (ram_data_o !== 32'hDEAD_BEEF)
      $display("FAIL prio_ram: got %h want deadbeef", ram_data_o);
    else n_pass++;
    n_tot++;
    if (rom_data_o !== 32'h0)
      $display("FAIL prio_rom: got %h want 0", rom_data_o);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_write();
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_0010;
    ram_ce_i = 1'b1; ram_we_i = 1'b1;
    ram_addr_i = 32'h0000_0040; ram_data_i = 32'h1234_5678;
    w0 = nwrites;
    observe(8, 20'd16);
    idle_inputs();
    @(posedge clk); #1;
    n_tot++;
    if (busy0 !== 1'b1) $display("FAIL wr_busy_accept: got %b want 1", busy0);
    else n_pass++;
    n_tot++;
    if (busy_cnt !== 4) $display("FAIL wr_busy_cnt: got %0d want 4", busy_cnt);
    else n_pass++;
    n_tot++;
    if (we_lo !== 2) $display("FAIL wr_we_cycles: got %0d want 2", we_lo);
    else n_pass++;
    n_tot++;
    if (we_bad !== 0) $display("FAIL wr_we_addr: got %0d bad want 0", we_bad);
    else n_pass++;
    n_tot++;
    if (ack_cnt !== 1) $display("FAIL wr_ack_cnt: got %0d want 1", ack_cnt);
    else n_pass++;
    n_tot++;
    if (ack_at !== 5) $display("FAIL wr_ack_at: got %0d want 5", ack_at);
    else n_pass++;
    n_tot++;
    if (rom_nz !== 0) $display("FAIL wr_rom_blocked: got %0d want 0", rom_nz);
    else n_pass++;
    n_tot++;
    if (mem[16] !== 32'h1234_5678)
      $display("FAIL wr_mem: got %h want 12345678", mem[16]);
    else n_pass++;
    n_tot++;
    if (nwrites - w0 !== 1)
      $display("FAIL wr_once: got %0d want 1", nwrites - w0);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    ram_ce_i = 1'b1; ram_we_i = 1'b1;
    ram_addr_i = 32'h8000_0000; ram_data_i = 32'hFFFF_FFFF;
    observe(6, 20'd0);
    idle_inputs();
    @(posedge clk); #1;
    n_tot++;
    if (ack_at !== 5) $display("FAIL oor_ack_at: got %0d want 5", ack_at);
    else n_pass++;
    n_tot++;
    if (busy_cnt !== 4) $display("FAIL oor_busy_cnt: got %0d want 4", busy_cnt);
    else n_pass++;
    n_tot++;
    if (ce_lo !== 0) $display("FAIL oor_ce: got %0d low want 0", ce_lo);
    else n_pass++;
    n_tot++;
    if (we_lo !== 0) $display("FAIL oor_we: got %0d low want 0", we_lo);
    else n_pass++;
    n_tot++;
    if (mem[0] !== 32'hA5A5_A5A5)
      $display("FAIL oor_mem: got %h want a5a5a5a5", mem[0]);
    else n_pass++;
    ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h8000_0000;
    @(negedge clk);
    n_tot++;
    if (ram_data_o !== 32'h0)
      $display("FAIL oor_load: got %h want 0", ram_data_o);
    else n_pass++;
    n_tot++;
    if (sram_ce_n !== 1'b1)
      $display("FAIL oor_load_ce: got %b want 1", sram_ce_n);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_write();
    ram_ce_i = 1'b1; ram_we_i = 1'b1;
    ram_addr_i = 32'h0000_0060; ram_data_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tot++;
    if (sram_we_n !== 1'b1)
      $display("FAIL rmid_we: got %b want 1", sram_we_n);
    else n_pass++;
    n_tot++;
    if (sram_dq_oe !== 1'b0)
      $display("FAIL rmid_dqoe: got %b want 0", sram_dq_oe);
    else n_pass++;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    observe(6, 20'd24);
    n_tot++;
    if (ack_cnt !== 0) $display("FAIL rmid_noack: got %0d want 0", ack_cnt);
    else n_pass++;
    n_tot++;
    if (busy_cnt !== 0) $display("FAIL rmid_idle: got %0d busy want 0", busy_cnt);
    else n_pass++;
    n_tot++;
    if (mem[24] !== 32'h1111_1111)
      $display("FAIL rmid_mem: got %h want 11111111", mem[24]);
    else n_pass++;
    ram_ce_i = 1'b1; ram_we_i = 1'b1;
    ram_addr_i = 32'h0000_0060; ram_data_i = 32'h0BAD_F00D;
    observe(6, 20'd24);
    idle_inputs();
    @(posedge clk); #1;
    n_tot++;
    if (ack_at !== 5) $display("FAIL rmid_new_ack: got %0d want 5", ack_at);
    else n_pass++;
    n_tot++;
    if (mem[24] !== 32'h0BAD_F00D)
      $display("FAIL rmid_new_mem: got %h want 0badf00d", mem[24]);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'hA5A5_A5A5;
    mem[4]  = 32'h2401_0005;
    mem[8]  = 32'hDEAD_BEEF;
    mem[24] = 32'h1111_1111;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_out_of_range();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
